pc_fetch: RTL and testbench



---
 rtl/pc_fetch.sv | 84 ++++++++
 tb/tb_pc_fetch.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/pc_fetch.sv
// Program counter and fetch sequencer: holds the PC, picks the next PC from decode
// feedback, and handles stall, JALR, halt, misaligned-target trap and retire count.
module pc_fetch #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  PCsrc,
  input  logic [DATA_WIDTH-1:0] ImmOp,
  input  logic                  JALRsrc,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic                  stall,
  input  logic                  halt_req,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] PCplus4,
  output logic                  fetch_valid,
  output logic                  misaligned,
  output logic                  halted,
  output logic [31:0]           instret
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] jalr_sum;

  // JALR targets are formed with bit 0 forced low before the alignment check.
  function automatic logic [DATA_WIDTH-1:0] clear_lsb(input logic [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-1:1], 1'b0};
  endfunction

  function automatic logic word_misaligned(input logic [DATA_WIDTH-1:0] v);
    return v[1:0] != 2'b00;
  endfunction

  assign PCplus4     = A + DATA_WIDTH'(4);
  assign jalr_sum    = rs1_data + ImmOp;
  assign fetch_valid = (state == RUN);
  assign halted      = (state == HALT);

  always_comb begin
    target = PCplus4;
    if (JALRsrc)
      target = clear_lsb(jalr_sum);
    else if (PCsrc)
      target = A + ImmOp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BOOT;
      A          <= RESET_VECTOR;
      instret    <= '0;
      misaligned <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          A     <= RESET_VECTOR;
          state <= RUN;
        end
        RUN: begin
          if (stall) begin
            state <= RUN;
          end else if (halt_req) begin
            instret <= instret + 32'd1;
            state   <= HALT;
          end else if (word_misaligned(target)) begin
            // The offending instruction does not retire; PC stays on it for debug.
            misaligned <= 1'b1;
            state      <= HALT;
          end else begin
            A       <= target;
            instret <= instret + 32'd1;
          end
        end
        HALT: state <= HALT;
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: two instances (reset vector 0 and 0xFFFF_FFF8) driven in lockstep,
// checked every cycle against a behavioural model plus directed expectations.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n, PCsrc, JALRsrc, stall, halt_req;
  logic [31:0] ImmOp, rs1_data;

  logic [31:0] a0, p40, ir0, a1, p41, ir1;
  logic        fv0, mis0, h0, fv1, mis1, h1;

  int tests = 0;
  int fails = 0;

  logic [31:0] rv [2] = '{32'h0000_0000, 32'hFFFF_FFF8};
  logic [31:0] m_pc [2];
  logic [31:0] m_ir [2];
  bit          m_mis [2];
  bit          m_boot [2];
  bit          m_stop [2];
  logic [31:0] saved_ir;

  always #5 clk = ~clk;

  pc_fetch #(.DATA_WIDTH(32), .RESET_VECTOR(32'h0000_0000)) dut0 (
    .clk(clk), .rst_n(rst_n), .PCsrc(PCsrc), .ImmOp(ImmOp), .JALRsrc(JALRsrc),
    .rs1_data(rs1_data), .stall(stall), .halt_req(halt_req), .A(a0), .PCplus4(p40),
    .fetch_valid(fv0), .misaligned(mis0), .halted(h0), .instret(ir0));

  pc_fetch #(.DATA_WIDTH(32), .RESET_VECTOR(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst_n(rst_n), .PCsrc(PCsrc), .ImmOp(ImmOp), .JALRsrc(JALRsrc),
    .rs1_data(rs1_data), .stall(stall), .halt_req(halt_req), .A(a1), .PCplus4(p41),
    .fetch_valid(fv1), .misaligned(mis1), .halted(h1), .instret(ir1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: what one clock edge does to the architectural state.
  task automatic model_edge(input int i);
    logic [31:0] t;
    if (!rst_n) begin
      m_pc[i] = rv[i]; m_ir[i] = 0; m_mis[i] = 0; m_boot[i] = 1; m_stop[i] = 0;
    end else if (m_boot[i]) begin
      m_boot[i] = 0;
    end else if (m_stop[i] || stall) begin
    end else if (halt_req) begin
      m_ir[i] = m_ir[i] + 1; m_stop[i] = 1;
    end else begin
      if (JALRsrc)    t = (rs1_data + ImmOp) & ~32'd1;
      else if (PCsrc) t = m_pc[i] + ImmOp;
      else            t = m_pc[i] + 4;
      if (t % 4 != 0) begin
        m_mis[i] = 1; m_stop[i] = 1;
      end else begin
        m_pc[i] = t; m_ir[i] = m_ir[i] + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("A0", a0, m_pc[0]);
    chk("PCplus4_0", p40, m_pc[0] + 4);
    chk("instret0", ir0, m_ir[0]);
    chk("misaligned0", {31'd0, mis0}, {31'd0, m_mis[0]});
    chk("fetch_valid0", {31'd0, fv0}, {31'd0, !m_boot[0] && !m_stop[0]});
    chk("halted0", {31'd0, h0}, {31'd0, m_stop[0]});
    chk("A1", a1, m_pc[1]);
    chk("PCplus4_1", p41, m_pc[1] + 4);
    chk("instret1", ir1, m_ir[1]);
    chk("misaligned1", {31'd0, mis1}, {31'd0, m_mis[1]});
    chk("fetch_valid1", {31'd0, fv1}, {31'd0, !m_boot[1] && !m_stop[1]});
    chk("halted1", {31'd0, h1}, {31'd0, m_stop[1]});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic r, input logic s, input logic h, input logic pc,
                       input logic j, input logic [31:0] imm, input logic [31:0] rs1);
    rst_n = r; stall = s; halt_req = h; PCsrc = pc; JALRsrc = j; ImmOp = imm; rs1_data = rs1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    // Reset two cycles, then free run.
    step(); step();
    chk("rst_A", a0, 32'h0); chk("rst_fv", {31'd0, fv0}, 32'd0); chk("rst_ir", ir0, 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(); chk("run_A0", a0, 32'h0); chk("run_fv", {31'd0, fv0}, 32'd1);
    chk("wrap_A1_first", a1, 32'hFFFF_FFF8);
    step(); chk("run_A4", a0, 32'h4); chk("wrap_A1_second", a1, 32'hFFFF_FFFC);
    step(); chk("run_A8", a0, 32'h8); chk("wrap_A1_third", a1, 32'h0);
    step(); chk("run_A12", a0, 32'hC); chk("run_ir3", ir0, 32'd3);
    step(); chk("run_A16", a0, 32'h10);
    // Backward branch, then JALR beating PCsrc with bit 0 cleared.
    drive(1, 0, 0, 1, 0, 32'hFFFF_FFF8, 0);
    step(); chk("branch_back", a0, 32'h8);
    drive(1, 0, 0, 1, 1, 32'h5, 32'h100);
    step(); chk("jalr_prio", a0, 32'h104); chk("jalr_prio1", a1, 32'h104);
    // Stall holds PC and instret even with a redirect pending.
    drive(1, 0, 0, 0, 1, 32'h0, 32'h20);
    step(); chk("goto_20", a0, 32'h20);
    saved_ir = ir0;
    drive(1, 1, 0, 1, 0, 32'h10, 0);
    for (int k = 0; k < 3; k++) begin
      step(); chk("stall_A", a0, 32'h20); chk("stall_ir", ir0, saved_ir);
    end
    drive(1, 0, 0, 1, 0, 32'h10, 0);
    step(); chk("stall_release", a0, 32'h30); chk("stall_release_ir", ir0, saved_ir + 1);
    // Misaligned branch target traps and freezes.
    drive(1, 0, 0, 0, 1, 32'h0, 32'h40);
    step(); chk("goto_40", a0, 32'h40);
    saved_ir = ir0;
    drive(1, 0, 0, 1, 0, 32'h2, 0);
    step();
    chk("mis_A", a0, 32'h40); chk("mis_flag", {31'd0, mis0}, 32'd1);
    chk("mis_halted", {31'd0, h0}, 32'd1); chk("mis_fv", {31'd0, fv0}, 32'd0);
    chk("mis_ir", ir0, saved_ir);
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, k[0], ~k[0], 0, 32'h8, 0);
      step(); chk("halt_frozen", a0, 32'h40);
    end
    // Reset out of HALT clears everything.
    drive(0, 0, 0, 1, 0, 32'h8, 0);
    step();
    chk("rst_halt_A", a0, 32'h0); chk("rst_halt_mis", {31'd0, mis0}, 32'd0);
    chk("rst_halt_ir", ir0, 32'd0); chk("rst_halt_h", {31'd0, h0}, 32'd0);
    // Wrap run on the high reset vector, then halt at 0.
    drive(1, 0, 0, 0, 0, 0, 0);
    step(); step(); step();
    chk("wrap_zero", a1, 32'h0); chk("wrap_no_mis", {31'd0, mis1}, 32'd0);
    drive(1, 0, 1, 0, 0, 0, 0);
    step();
    chk("halt_ir", ir1, 32'd3); chk("halt_h", {31'd0, h1}, 32'd1); chk("halt_A", a1, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 0);
    step(); chk("halt_hold", a1, 32'h0); chk("halt_hold_ir", ir1, 32'd3);
    // Reset in the middle of a stall.
    drive(0, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0); step(); step(); step();
    drive(1, 1, 0, 1, 0, 32'h40, 0); step();
    drive(0, 1, 0, 1, 0, 32'h40, 0); step();
    chk("rst_stall_A", a0, 32'h0); chk("rst_stall_ir", ir0, 32'd0);
    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] imm, rs1;
      imm = ($urandom_range(0, 15) == 0) ? $urandom() : (32'($urandom_range(0, 64)) - 32'd32) << 2;
      rs1 = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 255)) << 2;
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, imm, rs1);
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
